// File: rtl/disp_digit_sequencer.sv
// ---------------------------------------------------------------------------
// disp_digit_sequencer
//
// Holds six BCD digits (and optionally a decimal-point mask) for the
// six-digit seven-segment scanner and advances them on a prescaled step
// tick or a manual step request. Advancing means per-digit counting within
// [DIGIT_LO, DIGIT_HI] or rotating left/right. A load handshake replaces
// the contents.
//
// Optional feature macro: DISP_DIGIT_SEQUENCER_DP_EN
//   defined   : dp mask register exists, loads from load_dp_i, rotates with
//               the digits.
//   undefined : dp_o is tied to 0 and load_dp_i is ignored.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   mode_i[1:0]    00 HOLD, 01 COUNT, 10 ROT_L, 11 ROT_R
//   step_i         single-cycle manual advance request
//   load_valid_i   load request
//   load_ready_o   load accept
//   load_digits_i  new digits, digit k in bits [4k+3:4k], digit 0 rightmost
//   load_dp_i      new decimal-point mask, bit k belongs to digit k
//   digits_o       current digits (registered)
//   dp_o           current decimal-point mask (registered), 1 = lit
//   update_o       one-cycle pulse: digits_o/dp_o were written this cycle
//
// Load handshake: a load is accepted on a rising clk edge where both
// load_valid_i and load_ready_o are 1. load_ready_o is 1 in every cycle
// after reset release except the single cycle following an accepted load,
// so a valid held high is accepted every second cycle.
// ---------------------------------------------------------------------------
module disp_digit_sequencer #(
    parameter int unsigned STEP_DIV = 50_000_000,
    parameter int unsigned DIGIT_LO = 4,
    parameter int unsigned DIGIT_HI = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mode_i,
    input  logic        step_i,
    input  logic        load_valid_i,
    output logic        load_ready_o,
    input  logic [23:0] load_digits_i,
    input  logic [5:0]  load_dp_i,
    output logic [23:0] digits_o,
    output logic [5:0]  dp_o,
    output logic        update_o
);

    localparam int unsigned      CNT_W      = $clog2(STEP_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       LO         = 4'(DIGIT_LO);
    localparam logic [3:0]       HI         = 4'(DIGIT_HI);
    localparam logic [23:0]      DIGITS_RST = 24'h987654;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_COUNT = 2'b01,
        MODE_ROT_L = 2'b10,
        MODE_ROT_R = 2'b11
    } mode_e;

    mode_e            mode;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic [23:0]      digits_q, digits_d;
    logic             update_q, update_d;
    logic             tick;
    logic             accept;
    logic             advance;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        if (d < LO || d > HI) return LO;
        return d;
    endfunction

    function automatic logic [3:0] count_digit(input logic [3:0] d);
        if (d >= HI || d < LO) return LO;
        return d + 4'd1;
    endfunction

    assign mode   = mode_e'(mode_i);
    assign tick   = (cnt_q == CNT_MAX);
    assign accept = load_valid_i & ready_q;
    // A load in the same cycle swallows the advance; it is not remembered.
    // tick and step_i together still make a single advance.
    assign advance = (tick | step_i) & (mode != MODE_HOLD) & ~accept;

    always_comb begin
        cnt_d    = (accept || tick) ? '0 : cnt_q + CNT_ONE;
        ready_d  = ~accept;
        update_d = accept | advance;
        digits_d = digits_q;
        if (accept) begin
            for (int k = 0; k < 6; k++) begin
                digits_d[4*k +: 4] = clamp_digit(load_digits_i[4*k +: 4]);
            end
        end else if (advance) begin
            case (mode)
                MODE_COUNT: begin
                    for (int k = 0; k < 6; k++) begin
                        digits_d[4*k +: 4] = count_digit(digits_q[4*k +: 4]);
                    end
                end
                MODE_ROT_L: digits_d = {digits_q[19:0], digits_q[23:20]};
                MODE_ROT_R: digits_d = {digits_q[3:0], digits_q[23:4]};
                default:    digits_d = digits_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            digits_q <= DIGITS_RST;
            update_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            digits_q <= digits_d;
            update_q <= update_d;
        end
    end

    assign load_ready_o = ready_q;
    assign digits_o     = digits_q;
    assign update_o     = update_q;

`ifdef DISP_DIGIT_SEQUENCER_DP_EN
    localparam logic [5:0] DP_RST = 6'b010101;

    logic [5:0] dp_q, dp_d;

    // The mask follows the digits: loaded together, rotated together,
    // left alone by counting.
    always_comb begin
        dp_d = dp_q;
        if (accept) begin
            dp_d = load_dp_i;
        end else if (advance) begin
            case (mode)
                MODE_ROT_L: dp_d = {dp_q[4:0], dp_q[5]};
                MODE_ROT_R: dp_d = {dp_q[0], dp_q[5:1]};
                default:    dp_d = dp_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_q <= DP_RST;
        end else begin
            dp_q <= dp_d;
        end
    end

    assign dp_o = dp_q;
`else
    logic unused_load_dp;

    assign unused_load_dp = ^load_dp_i;
    assign dp_o           = 6'b000000;
`endif

endmodule

// File: tb/tb_disp_digit_sequencer.sv
// ---------------------------------------------------------------------------
// tb_disp_digit_sequencer
//
// Directed bench with STEP_DIV = 4. Stimulus tasks push the expected
// {digits, dp} for each update pulse into exp_q; a monitor pops and compares
// on every update_o pulse. Cycle-specific checks (reset values, ready,
// async reset) are made inline by the main process.
// ---------------------------------------------------------------------------
module tb_disp_digit_sequencer;

`ifdef DISP_DIGIT_SEQUENCER_DP_EN
    localparam bit DP_ON = 1'b1;
`else
    localparam bit DP_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode_i = 2'b01;
    logic        step_i = 1'b0;
    logic        load_valid_i = 1'b0;
    logic        load_ready_o;
    logic [23:0] load_digits_i = '0;
    logic [5:0]  load_dp_i = '0;
    logic [23:0] digits_o;
    logic [5:0]  dp_o;
    logic        update_o;

    always #5 clk = ~clk;

    disp_digit_sequencer #(
        .STEP_DIV (4),
        .DIGIT_LO (4),
        .DIGIT_HI (9)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mode_i        (mode_i),
        .step_i        (step_i),
        .load_valid_i  (load_valid_i),
        .load_ready_o  (load_ready_o),
        .load_digits_i (load_digits_i),
        .load_dp_i     (load_dp_i),
        .digits_o      (digits_o),
        .dp_o          (dp_o),
        .update_o      (update_o)
    );

    localparam logic [1:0] M_HOLD  = 2'b00;
    localparam logic [1:0] M_COUNT = 2'b01;
    localparam logic [1:0] M_ROT_L = 2'b10;
    localparam logic [1:0] M_ROT_R = 2'b11;

    // ---------------- scoreboard ----------------
    logic [29:0] exp_q[$];
    logic [29:0] mon_exp;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [5:0] edp(input logic [5:0] m);
        return DP_ON ? m : 6'b000000;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && update_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update: got digits=%h dp=%b, expected no update",
                         digits_o, dp_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({digits_o, dp_o} !== mon_exp) begin
                    errors++;
                    $display("FAIL update_value: got digits=%h dp=%b, expected digits=%h dp=%b",
                             digits_o, dp_o, mon_exp[29:6], mon_exp[5:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_load(input logic [23:0] d, input logic [5:0] p, input logic [23:0] exp_d);
        int n;
        n = 0;
        load_valid_i  = 1'b1;
        load_digits_i = d;
        load_dp_i     = p;
        while (!load_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!load_ready_o) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: got ready=0 for %0d cycles, expected ready=1", n);
        end else begin
            exp_q.push_back({exp_d, edp(p)});
        end
        @(negedge clk);
        load_valid_i = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset defaults
        cycles(2);
        check("rst_digits", 32'(digits_o), 32'h987654);
        check("rst_dp", 32'(dp_o), 32'(edp(6'b010101)));
        check("rst_update", 32'(update_o), 32'h0);
        check("rst_ready", 32'(load_ready_o), 32'h0);

        // First tick 4 edges after release, in COUNT mode
        rst_n = 1'b1;
        check("ready_before_edge", 32'(load_ready_o), 32'h0);
        exp_q.push_back({24'h498765, edp(6'b010101)});
        cycles(1);
        check("ready_after_release", 32'(load_ready_o), 32'h1);
        cycles(3);

        // COUNT wrap; prescaler restarts at the load
        do_load(24'h999999, 6'b000001, 24'h999999);
        exp_q.push_back({24'h444444, edp(6'b000001)});
        check("ready_after_load", 32'(load_ready_o), 32'h0);
        cycles(3);
        check("no_early_tick", 32'(digits_o), 32'h999999);
        cycles(1);

        // Load clamp, then HOLD ignores ticks and steps
        do_load(24'h0A3F95, 6'b100000, 24'h444495);
        mode_i = M_HOLD;
        cycles(2);
        step_i = 1'b1;
        cycles(1);
        step_i = 1'b0;
        cycles(5);
        check("hold_digits", 32'(digits_o), 32'h444495);
        check("hold_dp", 32'(dp_o), 32'(edp(6'b100000)));

        // Rotation left then right via step_i
        do_load(24'h987654, 6'b000001, 24'h987654);
        mode_i = M_ROT_L;
        step_i = 1'b1;
        exp_q.push_back({24'h876549, edp(6'b000010)});
        cycles(1);
        mode_i = M_ROT_R;
        exp_q.push_back({24'h987654, edp(6'b000001)});
        cycles(1);
        step_i = 1'b0;
        mode_i = M_HOLD;
        cycles(2);

        // step_i coinciding with tick gives a single advance
        mode_i = M_COUNT;
        do_load(24'h456789, 6'b111000, 24'h456789);
        cycles(3);
        step_i = 1'b1;
        exp_q.push_back({24'h567894, edp(6'b111000)});
        cycles(1);
        step_i = 1'b0;
        mode_i = M_HOLD;
        cycles(2);

        // Held valid across a tick: accepted, skipped one cycle, accepted again
        mode_i = M_COUNT;
        do_load(24'h555555, 6'b000000, 24'h555555);
        cycles(3);
        load_valid_i  = 1'b1;
        load_digits_i = 24'h777777;
        load_dp_i     = 6'b000111;
        exp_q.push_back({24'h777777, edp(6'b000111)});
        cycles(1);
        check("ready_gap", 32'(load_ready_o), 32'h0);
        cycles(1);
        check("ready_back", 32'(load_ready_o), 32'h1);
        exp_q.push_back({24'h777777, edp(6'b000111)});
        cycles(1);
        load_valid_i = 1'b0;
        mode_i = M_HOLD;
        cycles(3);
        check("after_double_load", 32'(digits_o), 32'h777777);

        // Async reset mid-cycle right after an advance
        mode_i = M_COUNT;
        step_i = 1'b1;
        @(posedge clk);
        #2;
        step_i = 1'b0;
        check("pre_reset_update", 32'(update_o), 32'h1);
        check("pre_reset_digits", 32'(digits_o), 32'h888888);
        rst_n = 1'b0;
        #1;
        check("async_digits", 32'(digits_o), 32'h987654);
        check("async_dp", 32'(dp_o), 32'(edp(6'b010101)));
        check("async_update", 32'(update_o), 32'h0);
        check("async_ready", 32'(load_ready_o), 32'h0);
        mode_i = M_HOLD;
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        check("ready_after_rerelease", 32'(load_ready_o), 32'h1);
        cycles(6);
        check("hold_after_reset", 32'(digits_o), 32'h987654);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
